// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption sequencer.
// Accepts a plaintext/key pair and applies the initial AddRoundKey itself.
// It then steps an external round unit and key-expansion step once per cycle
// for NR rounds, and presents the ciphertext over a valid/ready handshake.
// Optional feature macro: AES_CTRL_OVERLAP_EN. When it is defined, a new
// block can be accepted in the same cycle that the previous ciphertext is
// taken, which removes the idle bubble between blocks.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:DW-1] in_data,
    input  logic [0:DW-1] in_key,
    output logic [0:DW-1] rnd_state,
    output logic [0:DW-1] rnd_key,
    output logic          rnd_final,
    input  logic [0:DW-1] rnd_result,
    output logic [0:DW-1] ks_key,
    output logic [7:0]    ks_rcon,
    input  logic [0:DW-1] ks_next,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:DW-1] out_data,
    output logic          busy,
    output logic [3:0]    round_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] LAST_RND = 4'(NR);

`ifdef AES_CTRL_OVERLAP_EN
    localparam logic OVERLAP = 1'b1;
`else
    localparam logic OVERLAP = 1'b0;
`endif

    // GF(2^8) doubling used to advance the round constant
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    state_e          state_q, state_d;
    logic [0:DW-1]   data_q,  data_d;
    logic [0:DW-1]   key_q,   key_d;
    logic [7:0]      rcon_q,  rcon_d;
    logic [3:0]      cnt_q,   cnt_d;

    // Next-state logic: load a block, run one round per cycle, hold the result until taken
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_ROUND;
                    data_d  = in_data ^ in_key;
                    key_d   = in_key;
                    rcon_d  = 8'h01;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ROUND: begin
                data_d = rnd_result;
                key_d  = ks_next;
                rcon_d = xtime(rcon_q);
                if (cnt_q == LAST_RND) begin
                    // final round done; the counter keeps showing NR while the result waits
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    if (OVERLAP && in_valid) begin
                        // result leaves and the next block loads in the same cycle
                        state_d = S_ROUND;
                        data_d  = in_data ^ in_key;
                        key_d   = in_key;
                        rcon_d  = 8'h01;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rcon_q  <= 8'h01;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake and status outputs decoded from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rnd_final = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
            end
            S_ROUND: begin
                busy      = 1'b1;
                rnd_final = (cnt_q == LAST_RND);
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = OVERLAP & out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign rnd_state = data_q;
    assign rnd_key   = ks_next;
    assign ks_key    = key_q;
    assign ks_rcon   = rcon_q;
    assign out_data  = data_q;
    assign round_cnt = cnt_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with a behavioural AES round unit and key-expansion step.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int DW = 128;
    localparam logic [3:0] RN4 = 4'(NR);
`ifdef AES_CTRL_OVERLAP_EN
    localparam int SPACING = NR + 1;
`else
    localparam int SPACING = NR + 2;
`endif

    localparam logic [0:127] FIPS_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] FIPS_KY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_KY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [0:DW-1] in_data;
    logic [0:DW-1] in_key;
    logic [0:DW-1] rnd_state;
    logic [0:DW-1] rnd_key;
    logic          rnd_final;
    logic [0:DW-1] rnd_result;
    logic [0:DW-1] ks_key;
    logic [7:0]    ks_rcon;
    logic [0:DW-1] ks_next;
    logic          out_valid;
    logic          out_ready;
    logic [0:DW-1] out_data;
    logic          busy;
    logic [3:0]    round_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int out_cnt      = 0;
    logic [0:127] drv_exp;
    logic [0:127] exp_q[$];
    int           acc_q[$];
    logic         prev_ov = 1'b0;
    logic         prev_hs = 1'b0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_round_ctrl #(.NR(NR), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_final(rnd_final), .rnd_result(rnd_result),
        .ks_key(ks_key), .ks_rcon(ks_rcon), .ks_next(ks_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AES pieces ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] sq = x;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gm(sq, sq);
            inv = gm(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                               input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [0:127] o;
        for (int i = 0; i < 16; i++) b[i] = sb(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r + 4*c] = b[r + 4*((c + r) % 4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ k[8*i +: 8];
        return o;
    endfunction

    function automatic logic [0:127] key_exp(input logic [0:127] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[0 +: 32]; w1 = k[32 +: 32]; w2 = k[64 +: 32]; w3 = k[96 +: 32];
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rc, 24'h000000};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [0:127] aes_enc(input logic [0:127] pt, input logic [0:127] key);
        logic [0:127] s = pt ^ key;
        logic [0:127] k = key;
        logic [7:0]   rc = 8'h01;
        for (int r = 1; r <= NR; r++) begin
            k  = key_exp(k, rc);
            s  = aes_round(s, k, r == NR);
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
        end
        return s;
    endfunction

    always_comb ks_next    = key_exp(ks_key, ks_rcon);
    always_comb rnd_result = aes_round(rnd_state, rnd_key, rnd_final);

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: push on accept, compare while valid, pop on handshake
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_ov && !prev_hs) check_val("ov_hold", 128'(out_valid), 128'(1'b1));
            if (out_valid && !prev_ov) begin
                if (acc_q.size() > 0) check_val("latency", 128'(cyc - acc_q.pop_front()), 128'(NR + 1));
                else check_val("spurious_ov", 128'(1'b1), 128'(1'b0));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check_val("no_expect", 128'(1'b1), 128'(1'b0));
                else check_val("out_data", out_data, exp_q[0]);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                out_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(drv_exp);
                acc_q.push_back(cyc);
            end
            prev_ov = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    // drive a block and wait until it is accepted; in_valid is left high
    task automatic send_block(input logic [0:127] pt, input logic [0:127] k,
                              input logic [0:127] ex, output int acc_c);
        int n = 0;
        in_data  = pt;
        in_key   = k;
        drv_exp  = ex;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 60);
        if (!in_ready) check_val("tmo_accept", 128'(1'b0), 128'(1'b1));
        acc_c = cyc;
        @(posedge clk); #2;
    endtask

    task automatic wait_outputs(input int target);
        int n = 0;
        while (out_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (out_cnt < target) check_val("tmo_output", 128'(out_cnt), 128'(target));
    endtask

    logic [0:127] pt_a [4];
    logic [0:127] ky_a [4];
    logic [0:127] ct_a [4];
    int acc_c [4];
    int dummy_c;
    int rounds_seen;
    int n;
    int idx;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0; drv_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_val("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check_val("rst_busy", 128'(busy), 128'(1'b0));
        check_val("rst_final", 128'(rnd_final), 128'(1'b0));
        check_val("rst_round_cnt", 128'(round_cnt), 128'(4'd0));
        check_val("rst_rcon", 128'(ks_rcon), 128'(8'h01));
        check_val("rst_state", out_data, 128'h0);
        check_val("rst_key", ks_key, 128'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // FIPS-197 vector: rcon sequence and rnd_final, then hold in DONE
        send_block(FIPS_PT, FIPS_KY, FIPS_CT, dummy_c);
        in_valid = 1'b0;
        rounds_seen = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy && !out_valid) begin
                rounds_seen++;
                idx = int'(round_cnt) - 1;
                if (idx >= 0 && idx < NR) check_val("rcon", 128'(ks_rcon), 128'(rcon_tab[idx]));
                else check_val("round_range", 128'(round_cnt), 128'(4'd1));
                check_val("rnd_final", 128'(rnd_final), 128'(round_cnt == RN4));
            end
        end while (!out_valid && n < 40);
        check_val("rounds_seen", 128'(rounds_seen), 128'(NR));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            if (i == 0) begin
                in_valid = 1'b1; in_data = C1_PT; in_key = C1_KY; drv_exp = C1_CT;
            end
            @(negedge clk);
            check_val("done_in_ready", 128'(in_ready), 128'(1'b0));
            check_val("done_valid", 128'(out_valid), 128'(1'b1));
            check_val("done_cnt", 128'(round_cnt), 128'(RN4));
            check_val("done_final", 128'(rnd_final), 128'(1'b0));
        end
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        @(negedge clk);
        check_val("idle_in_ready", 128'(in_ready), 128'(1'b1));
        check_val("idle_busy", 128'(busy), 128'(1'b0));
        check_val("idle_cnt", 128'(round_cnt), 128'(4'd0));
        check_val("outs_a", 128'(out_cnt), 128'(1));

        // reset in the middle of the rounds discards the block
        @(posedge clk); #2;
        send_block(C1_PT, C1_KY, C1_CT, dummy_c);
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (round_cnt != 4'd3 && n < 40);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_in_ready", 128'(in_ready), 128'(1'b1));
        check_val("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        check_val("mid_rst_busy", 128'(busy), 128'(1'b0));
        check_val("mid_rst_cnt", 128'(round_cnt), 128'(4'd0));
        @(posedge clk); #2;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_val("discarded", 128'(out_cnt), 128'(1));
        @(posedge clk); #2;
        send_block(C1_PT, C1_KY, C1_CT, dummy_c);
        in_valid = 1'b0;
        wait_outputs(2);

        // back-to-back blocks with in_valid and out_ready held high
        pt_a[0] = FIPS_PT; ky_a[0] = FIPS_KY; ct_a[0] = FIPS_CT;
        pt_a[1] = C1_PT;   ky_a[1] = C1_KY;   ct_a[1] = C1_CT;
        for (int i = 2; i < 4; i++) begin
            pt_a[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ky_a[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct_a[i] = aes_enc(pt_a[i], ky_a[i]);
        end
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) send_block(pt_a[i], ky_a[i], ct_a[i], acc_c[i]);
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++)
            check_val("spacing", 128'(acc_c[i] - acc_c[i-1]), 128'(SPACING));
        wait_outputs(6);
        repeat (3) @(negedge clk);
        check_val("queue_empty", 128'(exp_q.size()), 128'(0));
        check_val("outs_total", 128'(out_cnt), 128'(6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
